// File: rtl/merge_feeder.sv
// merge_feeder: collects two sorted halves of n elements each from a
// valid/ready stream and presents them side by side on inba, pulsing
// load[0] when half A is complete and load[1] when half B is complete.
// Optional sort-order checking is compiled in with MERGE_FEEDER_SORT_CHECK_EN.
module merge_feeder #(
  parameter int WIDTH = 8,
  parameter int n     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     abort,
  output logic [1:0]               load,
  output logic [2*n*WIDTH-1:0]     inba,
  output logic                     busy,
  output logic                     err
);

  localparam int CW = (n > 1) ? $clog2(n + 1) : 1;
  localparam int IW = $clog2(2 * n);
  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    LOAD_A = 2'd1,
    FILL_B = 2'd2,
    LOAD_B = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [1:0]      load_reg;

  logic            filling;
  logic            accept;
  logic            last_elem;
  logic [IW-1:0]   wr_idx;

  // Abort suppresses acceptance, so in_ready drops with it to keep the
  // handshake truthful.
  assign filling   = (state_reg == FILL_A) || (state_reg == FILL_B);
  assign in_ready  = rst && filling && !abort;
  assign accept    = in_valid && in_ready;
  assign last_elem = (count_reg == LAST_CNT);
  assign wr_idx    = ((state_reg == FILL_B) ? IW'(n) : IW'(0)) + IW'(count_reg);

  assign load = load_reg;
  assign busy = (state_reg != FILL_A) || (count_reg != '0);

  // Sequencer: counts accepted elements and emits one-cycle load pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FILL_A;
      count_reg <= '0;
      load_reg  <= 2'b00;
    end else begin
      load_reg <= 2'b00;
      case (state_reg)
        FILL_A, FILL_B: begin
          if (abort) begin
            count_reg <= '0;
            state_reg <= FILL_A;
          end else if (accept) begin
            if (last_elem) begin
              count_reg <= '0;
              if (state_reg == FILL_A) begin
                state_reg <= LOAD_A;
                load_reg  <= 2'b01;
              end else begin
                state_reg <= LOAD_B;
                load_reg  <= 2'b10;
              end
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        LOAD_A:  state_reg <= FILL_B;
        LOAD_B:  state_reg <= FILL_A;
        default: state_reg <= FILL_A;
      endcase
    end
  end

  // One register per slot; a slot only changes when its own element arrives.
  generate
    for (genvar gi = 0; gi < 2 * n; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;

      // Capture the accepted element addressed to this slot.
      always_ff @(posedge clk) begin
        if (!rst) begin
          slot_reg <= '0;
        end else if (accept && (wr_idx == IW'(gi))) begin
          slot_reg <= in_data;
        end
      end

      assign inba[gi*WIDTH +: WIDTH] = slot_reg;
    end
  endgenerate

`ifdef MERGE_FEEDER_SORT_CHECK_EN
  logic [WIDTH-1:0] last_reg;
  logic             err_reg;

  // Sticky flag for an element smaller than its predecessor in the same half;
  // the first element of a half (count 0) has no predecessor to compare with.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg <= '0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      last_reg <= in_data;
      if ((count_reg != '0) && (in_data < last_reg)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_feeder.sv
// Directed bench for merge_feeder (WIDTH=8, n=8). Expected err follows the
// MERGE_FEEDER_SORT_CHECK_EN build setting.
module tb_merge_feeder;

  localparam int W = 8;
  localparam int N = 8;

`ifdef MERGE_FEEDER_SORT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [63:0] A_DATA   = 64'hD2D0CFCCC9C80000;
  localparam logic [63:0] B_DATA   = 64'h1407060504030201;
  localparam logic [63:0] BAD_DATA = 64'h0B0A090807060305;
  localparam logic [63:0] A2_DATA  = 64'h50463C32281E140A;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             abort;
  logic [1:0]       load;
  logic [2*N*W-1:0] inba;
  logic             busy;
  logic             err;

  logic acc;
  logic rdy;
  int   total;
  int   fails;
  int   fw;

  merge_feeder #(.WIDTH(W), .n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .abort    (abort),
    .load     (load),
    .inba     (inba),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, note the handshake, settle past the rising edge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic ab, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    abort    = ab;
    rst      = r;
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Hold one element valid until accepted, bounded to 8 tries.
  task automatic send(input logic [W-1:0] d, output int waits);
    waits = 0;
    tick(1'b1, d, 1'b0, 1'b1);
    while (!acc && waits < 8) begin
      waits++;
      tick(1'b1, d, 1'b0, 1'b1);
    end
    if (!acc) chk("accept_timeout", {127'd0, acc}, 128'd1);
    $display("send %02h waits=%0d load=%b busy=%b err=%b", d, waits, load, busy, err);
  endtask

  task automatic send_half(input logic [63:0] vals, input logic toggle, output int first_wait);
    int w;
    first_wait = 0;
    for (int k = 0; k < N; k++) begin
      if (toggle && k > 0) tick(1'b0, 8'hEE, 1'b0, 1'b1);
      send(vals[k*8 +: 8], w);
      if (k == 0) first_wait = w;
    end
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int w;
    total = 0;
    fails = 0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    rst      = 1'b0;

    // Reset for two cycles
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_in_ready_1", {127'd0, rdy}, 128'd0);
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    chk("rst_in_ready_2", {127'd0, rdy}, 128'd0);
    chk("rst_load", {126'd0, load}, 128'd0);
    chk("rst_inba", inba, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);

    // Contiguous stream
    send_half(A_DATA, 1'b0, fw);
    chk("c_a_first_wait", fw, 0);
    chk("c_load_a", {126'd0, load}, 128'd1);
    chk("c_inba_a", {64'd0, inba[63:0]}, {64'd0, A_DATA});
    chk("c_busy_load_a", {127'd0, busy}, 128'd1);
    send_half(B_DATA, 1'b0, fw);
    chk("c_b_first_wait", fw, 1);
    chk("c_load_b", {126'd0, load}, 128'd2);
    chk("c_inba", inba, {B_DATA, A_DATA});
    chk("c_err", {127'd0, err}, 128'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("c_load_idle", {126'd0, load}, 128'd0);
    chk("c_busy_idle", {127'd0, busy}, 128'd0);

    // in_valid toggling, held high through LOAD states
    do_reset();
    send_half(A_DATA, 1'b1, fw);
    chk("t_load_a", {126'd0, load}, 128'd1);
    chk("t_inba_a", {64'd0, inba[63:0]}, {64'd0, A_DATA});
    tick(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("t_load_a_acc", {127'd0, acc}, 128'd0);
    chk("t_load_a_end", {126'd0, load}, 128'd0);
    send_half(B_DATA, 1'b1, fw);
    chk("t_load_b", {126'd0, load}, 128'd2);
    chk("t_inba", inba, {B_DATA, A_DATA});
    tick(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("t_load_b_acc", {127'd0, acc}, 128'd0);
    chk("t_load_b_end", {126'd0, load}, 128'd0);

    // Out-of-order A stream
    do_reset();
    send(8'h05, w);
    chk("s_busy_count1", {127'd0, busy}, 128'd1);
    chk("s_err_first", {127'd0, err}, 128'd0);
    send(8'h03, w);
    chk("s_err_after_3", {127'd0, err}, {127'd0, EXP_ERR});
    for (int k = 2; k < N; k++) send(BAD_DATA[k*8 +: 8], w);
    chk("s_load_a", {126'd0, load}, 128'd1);
    chk("s_err_sticky", {127'd0, err}, {127'd0, EXP_ERR});
    chk("s_inba_a", {64'd0, inba[63:0]}, {64'd0, BAD_DATA});

    // Abort after 5 B elements
    do_reset();
    send_half(A_DATA, 1'b0, fw);
    for (int k = 0; k < 5; k++) send(B_DATA[k*8 +: 8], w);
    chk("a_busy_before", {127'd0, busy}, 128'd1);
    tick(1'b1, 8'h99, 1'b1, 1'b1);
    chk("a_acc", {127'd0, acc}, 128'd0);
    chk("a_load", {126'd0, load}, 128'd0);
    chk("a_busy_after", {127'd0, busy}, 128'd0);
    chk("a_inba_kept", inba, {64'h0000000504030201, A_DATA});
    send_half(A2_DATA, 1'b0, fw);
    chk("a_load_a", {126'd0, load}, 128'd1);
    chk("a_inba_a", inba, {64'h0000000504030201, A2_DATA});
    send_half(B_DATA, 1'b0, fw);
    chk("a_load_b", {126'd0, load}, 128'd2);
    chk("a_inba", inba, {B_DATA, A2_DATA});

    // Reset after 3 B elements
    send_half(A_DATA, 1'b0, fw);
    for (int k = 0; k < 3; k++) send(B_DATA[k*8 +: 8], w);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    chk("r_in_ready", {127'd0, rdy}, 128'd0);
    chk("r_load", {126'd0, load}, 128'd0);
    chk("r_inba", inba, 128'd0);
    chk("r_busy", {127'd0, busy}, 128'd0);
    chk("r_err", {127'd0, err}, 128'd0);
    send_half(A2_DATA, 1'b0, fw);
    chk("r_load_a", {126'd0, load}, 128'd1);
    chk("r_inba_a", inba, {64'd0, A2_DATA});
    send_half(B_DATA, 1'b0, fw);
    chk("r_load_b", {126'd0, load}, 128'd2);
    chk("r_inba", inba, {B_DATA, A2_DATA});

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
